slavefifo_mode_arbiter: RTL and testbench

SLAVEFIFO_MODE_ARBITER -- requirements
Module: slavefifo_mode_arbiter

---
 rtl/slavefifo_mode_arbiter_if.sv | 38 +++
 rtl/slavefifo_mode_arbiter.sv | 167 ++++++++++++++++
 tb/tb_slavefifo_mode_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/slavefifo_mode_arbiter_if.sv
// rtl/slavefifo_mode_arbiter_if.sv - request/grant and FX3 strobe bundle for the slave-FIFO mode arbiter
interface slavefifo_mode_arbiter_if;
  // requests and completion pulses from the two streaming sub-FSMs
  logic       in_req;
  logic       out_req;
  logic       in_done;
  logic       out_done;
  // active-low strobes produced by the sub-FSMs
  logic       slwr_in_;
  logic       pktend_in_;
  logic       slrd_out_;
  logic       sloe_out_;
  // grants back to the sub-FSMs and gated strobes to the FX3 pins
  logic       stream_in_mode_selected;
  logic       stream_out_mode_selected;
  logic [1:0] faddr;
  logic       slwr_;
  logic       pktend_;
  logic       slrd_;
  logic       sloe_;
  logic       busy;

  // requester / pin side
  modport master (
    output in_req, out_req, in_done, out_done,
    output slwr_in_, pktend_in_, slrd_out_, sloe_out_,
    input  stream_in_mode_selected, stream_out_mode_selected,
    input  faddr, slwr_, pktend_, slrd_, sloe_, busy
  );

  // arbiter side
  modport slave (
    input  in_req, out_req, in_done, out_done,
    input  slwr_in_, pktend_in_, slrd_out_, sloe_out_,
    output stream_in_mode_selected, stream_out_mode_selected,
    output faddr, slwr_, pktend_, slrd_, sloe_, busy
  );
endinterface

// File: rtl/slavefifo_mode_arbiter.sv
// rtl/slavefifo_mode_arbiter.sv - round-robin IN/OUT owner of the FX3 slave-FIFO bus; SLFIFO_ARB_PREEMPT_EN enables burst preemption
module slavefifo_mode_arbiter #(
  parameter int unsigned TURN_GAP  = 3,
  parameter int unsigned MAX_BURST = 1024
) (
  input  logic                    clk_100,
  input  logic                    reset_,
  slavefifo_mode_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_GRANT_IN       = 3'd1,
    S_GRANT_OUT      = 3'd2,
    S_TURN           = 3'd3,
    S_GRANT_IN_WAIT  = 3'd4,
    S_GRANT_OUT_WAIT = 3'd5
  } state_t;

  localparam logic [1:0] FADDR_IN   = 2'b00;
  localparam logic [1:0] FADDR_OUT  = 2'b11;
  // counter runs TURN_GAP-1 .. 0, so TURN is occupied exactly TURN_GAP cycles
  localparam logic [3:0] TURN_LOAD  = 4'(TURN_GAP - 1);

  state_t     state;
  logic       in_sel;
  logic       out_sel;
  logic [1:0] faddr_q;
  logic       busy_q;
  logic [3:0] turn_cnt;
  // set when the most recent grant went to IN; resets to "OUT was last" so IN wins the first tie
  logic       last_in;
  logic       in_owns;
  logic       out_owns;

`ifdef SLFIFO_ARB_PREEMPT_EN
  localparam logic [15:0] BURST_LAST = 16'(MAX_BURST - 1);
  logic [15:0] burst_cnt;
`endif

  // arbitration FSM with registered grant, address and busy outputs
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      state    <= S_IDLE;
      in_sel   <= 1'b0;
      out_sel  <= 1'b0;
      faddr_q  <= FADDR_IN;
      busy_q   <= 1'b0;
      turn_cnt <= 4'd0;
      last_in  <= 1'b0;
`ifdef SLFIFO_ARB_PREEMPT_EN
      burst_cnt <= 16'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_req && (!bus.out_req || !last_in)) begin
            state   <= S_GRANT_IN;
            in_sel  <= 1'b1;
            faddr_q <= FADDR_IN;
            busy_q  <= 1'b1;
            last_in <= 1'b1;
`ifdef SLFIFO_ARB_PREEMPT_EN
            burst_cnt <= 16'd0;
`endif
          end else if (bus.out_req) begin
            state   <= S_GRANT_OUT;
            out_sel <= 1'b1;
            faddr_q <= FADDR_OUT;
            busy_q  <= 1'b1;
            last_in <= 1'b0;
`ifdef SLFIFO_ARB_PREEMPT_EN
            burst_cnt <= 16'd0;
`endif
          end
        end

        S_GRANT_IN: begin
          if (bus.in_done) begin
            state    <= S_TURN;
            in_sel   <= 1'b0;
            turn_cnt <= TURN_LOAD;
          end
`ifdef SLFIFO_ARB_PREEMPT_EN
          else if (bus.out_req) begin
            burst_cnt <= burst_cnt + 16'd1;
            if (burst_cnt == BURST_LAST) begin
              state  <= S_GRANT_IN_WAIT;
              in_sel <= 1'b0;
            end
          end
`endif
        end

        S_GRANT_OUT: begin
          if (bus.out_done) begin
            state    <= S_TURN;
            out_sel  <= 1'b0;
            turn_cnt <= TURN_LOAD;
          end
`ifdef SLFIFO_ARB_PREEMPT_EN
          else if (bus.in_req) begin
            burst_cnt <= burst_cnt + 16'd1;
            if (burst_cnt == BURST_LAST) begin
              state   <= S_GRANT_OUT_WAIT;
              out_sel <= 1'b0;
            end
          end
`endif
        end

`ifdef SLFIFO_ARB_PREEMPT_EN
        // preempted: the sub-FSM finishes its packet with strobes still live
        S_GRANT_IN_WAIT: begin
          if (bus.in_done) begin
            state    <= S_TURN;
            turn_cnt <= TURN_LOAD;
          end
        end

        S_GRANT_OUT_WAIT: begin
          if (bus.out_done) begin
            state    <= S_TURN;
            turn_cnt <= TURN_LOAD;
          end
        end
`endif

        S_TURN: begin
          if (turn_cnt == 4'd0) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            turn_cnt <= turn_cnt - 4'd1;
          end
        end

        default: begin
          state   <= S_IDLE;
          in_sel  <= 1'b0;
          out_sel <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // which side's strobes currently reach the pins (preempted owners keep them)
  always_comb begin
    in_owns  = (state == S_GRANT_IN);
    out_owns = (state == S_GRANT_OUT);
`ifdef SLFIFO_ARB_PREEMPT_EN
    if (state == S_GRANT_IN_WAIT)  in_owns  = 1'b1;
    if (state == S_GRANT_OUT_WAIT) out_owns = 1'b1;
`endif
  end

  assign bus.stream_in_mode_selected  = in_sel;
  assign bus.stream_out_mode_selected = out_sel;
  assign bus.faddr                    = faddr_q;
  assign bus.busy                     = busy_q;
  assign bus.slwr_                    = in_owns  ? bus.slwr_in_   : 1'b1;
  assign bus.pktend_                  = in_owns  ? bus.pktend_in_ : 1'b1;
  assign bus.slrd_                    = out_owns ? bus.slrd_out_  : 1'b1;
  assign bus.sloe_                    = out_owns ? bus.sloe_out_  : 1'b1;

endmodule

// File: tb/tb_slavefifo_mode_arbiter.sv
// tb/tb_slavefifo_mode_arbiter.sv - directed and random checks of slavefifo_mode_arbiter against a bus-ownership model
module tb_slavefifo_mode_arbiter;
  localparam int TG = 3;
`ifdef SLFIFO_ARB_PREEMPT_EN
  localparam int MB = 8;
`else
  localparam int MB = 1024;
`endif

  logic clk_100 = 1'b0;
  logic reset_  = 1'b0;
  always #5 clk_100 = ~clk_100;

  slavefifo_mode_arbiter_if bus ();

  slavefifo_mode_arbiter #(.TURN_GAP(TG), .MAX_BURST(MB)) dut (
    .clk_100 (clk_100),
    .reset_  (reset_),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // model: who owns the bus (0 none, 1 IN, 2 OUT), whether the grant line is
  // still up, remaining idle gap cycles, and who was served most recently
  int         m_owner;
  bit         m_sel;
  int         m_gap;
  bit         m_last_out;
  logic [1:0] m_faddr;
  int         m_burst;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_sel = 0; m_gap = 0; m_last_out = 1; m_faddr = 2'b00; m_burst = 0;
  endtask

  task automatic model_step();
    bit want_in;
    if (m_owner != 0) begin
      if ((m_owner == 1 && bus.in_done) || (m_owner == 2 && bus.out_done)) begin
        m_owner = 0; m_sel = 0; m_gap = TG;
      end
`ifdef SLFIFO_ARB_PREEMPT_EN
      else if (m_sel && ((m_owner == 1 && bus.out_req) || (m_owner == 2 && bus.in_req))) begin
        m_burst++;
        if (m_burst == MB) m_sel = 0;
      end
`endif
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (bus.in_req || bus.out_req) begin
      want_in    = (bus.in_req && bus.out_req) ? m_last_out : bus.in_req;
      m_owner    = want_in ? 1 : 2;
      m_sel      = 1;
      m_burst    = 0;
      m_faddr    = want_in ? 2'b00 : 2'b11;
      m_last_out = !want_in;
    end
  endtask

  task automatic tick();
    @(posedge clk_100);
    if (!reset_) model_reset();
    else model_step();
    #1;
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".in_sel"},  16'(bus.stream_in_mode_selected),  16'(m_owner == 1 && m_sel));
    chk({tag, ".out_sel"}, 16'(bus.stream_out_mode_selected), 16'(m_owner == 2 && m_sel));
    chk({tag, ".faddr"},   16'(bus.faddr),  16'(m_faddr));
    chk({tag, ".busy"},    16'(bus.busy),   16'(m_owner != 0 || m_gap > 0));
    chk({tag, ".slwr"},    16'(bus.slwr_),   16'(m_owner == 1 ? bus.slwr_in_   : 1'b1));
    chk({tag, ".pktend"},  16'(bus.pktend_), 16'(m_owner == 1 ? bus.pktend_in_ : 1'b1));
    chk({tag, ".slrd"},    16'(bus.slrd_),   16'(m_owner == 2 ? bus.slrd_out_  : 1'b1));
    chk({tag, ".sloe"},    16'(bus.sloe_),   16'(m_owner == 2 ? bus.sloe_out_  : 1'b1));
  endtask

  task automatic idle_inputs();
    bus.in_req = 0; bus.out_req = 0; bus.in_done = 0; bus.out_done = 0;
    bus.slwr_in_ = 1; bus.pktend_in_ = 1; bus.slrd_out_ = 1; bus.sloe_out_ = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_ = 0;
    model_reset();
    tick();
    tick();
    reset_ = 1;
  endtask

  initial begin
    int cnt;
    idle_inputs();
    model_reset();

    // reset state
    tick();
    tick();
    check_all("reset");
    chk("reset.faddr_const", 16'(bus.faddr), 16'h0);
    chk("reset.busy_const",  16'(bus.busy),  16'h0);

    // request present as reset releases: granted on the first edge
    bus.in_req = 1;
    reset_ = 1;
    tick();
    bus.slwr_in_ = 0;
    check_all("first_grant");
    chk("first_grant.in_sel", 16'(bus.stream_in_mode_selected), 16'h1);
    chk("first_grant.slwr",   16'(bus.slwr_), 16'h0);

    // both requesting, IN finishes, idle gap, then OUT
    bus.out_req = 1;
    bus.in_done = 1;
    check_all("in_done");
    tick();
    bus.in_done = 0;
    for (int i = 0; i < TG; i++) begin
      check_all("turn");
      chk("turn.slwr_high", 16'(bus.slwr_), 16'h1);
      tick();
    end
    check_all("back_idle");
    tick();
    check_all("out_grant");
    chk("out_grant.faddr",   16'(bus.faddr), 16'h3);
    chk("out_grant.out_sel", 16'(bus.stream_out_mode_selected), 16'h1);

    // only OUT strobes reach the pins while OUT owns the bus
    bus.slrd_out_ = 0; bus.slwr_in_ = 0; bus.pktend_in_ = 0;
    check_all("out_strobes");
    chk("out_strobes.slrd",   16'(bus.slrd_),   16'h0);
    chk("out_strobes.slwr",   16'(bus.slwr_),   16'h1);
    chk("out_strobes.pktend", 16'(bus.pktend_), 16'h1);

    // asynchronous reset in the middle of an OUT grant
    bus.sloe_out_ = 0;
    #1;
    chk("pre_reset.sloe", 16'(bus.sloe_), 16'h0);
    reset_ = 0;
    model_reset();
    #1;
    chk("async_reset.sloe", 16'(bus.sloe_), 16'h1);
    chk("async_reset.busy", 16'(bus.busy),  16'h0);
    check_all("async_reset");
    idle_inputs();
    tick();
    tick();
    reset_ = 1;
    check_all("after_reset");

    // grant survives request drop and the other side's done pulse
    bus.in_req = 1;
    tick();
    check_all("hold_start");
    bus.in_req = 0; bus.out_req = 1; bus.out_done = 1;
    check_all("hold_other_done");
    tick();
    bus.out_done = 0;
    for (int i = 0; i < 4; i++) begin
      check_all("hold");
      chk("hold.in_sel", 16'(bus.stream_in_mode_selected), 16'h1);
      tick();
    end
    bus.in_done = 1;
    tick();
    bus.in_done = 0;
    check_all("hold_end");
    chk("hold_end.in_sel", 16'(bus.stream_in_mode_selected), 16'h0);
    chk("hold_end.busy",   16'(bus.busy), 16'h1);

`ifdef SLFIFO_ARB_PREEMPT_EN
    // preemption: IN grant line drops after MB cycles while OUT waits
    do_reset();
    bus.in_req = 1; bus.out_req = 1;
    tick();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      check_all("burst");
      if (bus.stream_in_mode_selected === 1'b1) cnt++;
      tick();
    end
    chk("burst.len", 16'(cnt), 16'(MB));
    bus.slwr_in_ = 0;
    check_all("burst_wait_strobe");
    chk("burst_wait.slwr", 16'(bus.slwr_), 16'h0);
    bus.in_done = 1;
    tick();
    bus.in_done = 0;
    bus.slwr_in_ = 1;
    for (int i = 0; i < TG + 1; i++) begin
      check_all("burst_turn");
      tick();
    end
    check_all("burst_out");
    chk("burst_out.out_sel", 16'(bus.stream_out_mode_selected), 16'h1);
`endif

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bus.in_req     = ($urandom_range(0, 3) != 0);
      bus.out_req    = ($urandom_range(0, 3) != 0);
      bus.in_done    = ($urandom_range(0, 6) == 0);
      bus.out_done   = ($urandom_range(0, 6) == 0);
      bus.slwr_in_   = 1'($urandom);
      bus.pktend_in_ = 1'($urandom);
      bus.slrd_out_  = 1'($urandom);
      bus.sloe_out_  = 1'($urandom);
      check_all("rand");
      if ($urandom_range(0, 299) == 0) begin
        reset_ = 0;
        model_reset();
        check_all("rand_reset");
        tick();
        reset_ = 1;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
